// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and helpers for the CORDIC frequency demodulator
package cordic_pkg;
  localparam int FREQ_BITS = 16;
  localparam int MAG_BITS = 12;
  typedef enum logic {S_EMPTY, S_RUN} state_t;
  typedef struct packed {
    logic [FREQ_BITS-1:0] freq;
    logic [MAG_BITS-1:0]  mag;
    logic                 squelch;
  } fifo_entry_t;
  function automatic int log2_decim(input int d);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < d) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/cordic_sync_fifo.sv
// cordic_sync_fifo: synchronous FIFO; a push onto a full FIFO lands only if a pop frees a slot that cycle
module cordic_sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_pop, do_push;
  assign empty = wr == rd;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wr <= '0;
      rd <= '0;
    end else if (clear) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + (AW+1)'(1);
      if (do_pop) rd <= rd + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cordic_freq_demod.sv
// cordic_freq_demod: phase differentiator with accumulate-and-dump averaging, squelch and output FIFO
module cordic_freq_demod
  import cordic_pkg::*;
#(
  parameter int PH_BITS    = 32,
  parameter int XY_BITS    = MAG_BITS,
  parameter int OUT_BITS   = FREQ_BITS,
  parameter int DECIM      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SQL_LEVEL  = 64
) (
  input  logic                clk,
  input  logic                RST_n,
  input  logic                clear,
  input  logic                valid_in,
  input  logic [PH_BITS-1:0]  phase_in,
  input  logic [XY_BITS-1:0]  mag_in,
  output logic [OUT_BITS-1:0] freq_o,
  output logic [XY_BITS-1:0]  mag_o,
  output logic                squelch_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o
);
  localparam int LOG2_DECIM = log2_decim(DECIM);
  localparam int CW = LOG2_DECIM > 0 ? LOG2_DECIM : 1;
  localparam int AW = PH_BITS + LOG2_DECIM;
  localparam int EW = $bits(fifo_entry_t);
  state_t state;
  logic [PH_BITS-1:0] prev_ph;
  logic signed [PH_BITS-1:0] diff;
  logic signed [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [OUT_BITS-1:0] result;
  logic low_seen, low, dump, sq, res_vld, overrun, full, empty;
  fifo_entry_t res_q, head;
  logic [EW-1:0] dout;
  assign diff = phase_in - prev_ph;
  assign sum = acc + AW'(diff);
  // (sum >>> LOG2_DECIM)[PH_BITS-1 -: OUT_BITS] is just the top OUT_BITS of sum
  assign result = sum[AW-1 -: OUT_BITS];
  assign low = mag_in < XY_BITS'(SQL_LEVEL);
  assign sq = low_seen || low;
  assign dump = state == S_RUN && cnt == CW'(DECIM - 1);
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_EMPTY;
      prev_ph <= '0;
      acc <= '0;
      cnt <= '0;
      low_seen <= 1'b0;
      res_vld <= 1'b0;
      res_q <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      state <= S_EMPTY;
      prev_ph <= '0;
      acc <= '0;
      cnt <= '0;
      low_seen <= 1'b0;
      res_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (res_vld && full && !(valid_o && ready_i)) overrun <= 1'b1;
      if (valid_in) begin
        prev_ph <= phase_in;
        if (state == S_EMPTY) begin
          state <= S_RUN;
          low_seen <= sq;
        end else if (dump) begin
          acc <= '0;
          cnt <= '0;
          low_seen <= 1'b0;
          res_vld <= 1'b1;
          res_q <= '{freq: sq ? '0 : FREQ_BITS'(result), mag: MAG_BITS'(mag_in), squelch: sq};
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
          low_seen <= sq;
        end
      end
    end
  end
  cordic_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .RST_n(RST_n),
    .clear(clear),
    .push(res_vld),
    .pop(valid_o && ready_i),
    .din(res_q),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  assign head = dout;
  assign freq_o = OUT_BITS'(head.freq);
  assign mag_o = XY_BITS'(head.mag);
  assign squelch_o = head.squelch;
  assign valid_o = !empty;
  assign overrun_o = overrun;
endmodule

// File: tb/tb_cordic_freq_demod.sv
// tb_cordic_freq_demod: directed table-driven bench for cordic_freq_demod with DECIM=4
module tb_cordic_freq_demod;
  logic clk = 0, RST_n = 0, clear = 0, valid_in = 0, ready_i = 1;
  logic [31:0] phase_in = 0;
  logic [11:0] mag_in = 0;
  logic [15:0] freq_o;
  logic [11:0] mag_o;
  logic squelch_o, valid_o, overrun_o;
  int tests = 0, fails = 0;
  logic [31:0] ph;

  cordic_freq_demod #(.PH_BITS(32), .XY_BITS(12), .OUT_BITS(16), .DECIM(4), .FIFO_DEPTH(4), .SQL_LEVEL(64)) dut (
    .clk(clk), .RST_n(RST_n), .clear(clear), .valid_in(valid_in), .phase_in(phase_in), .mag_in(mag_in),
    .freq_o(freq_o), .mag_o(mag_o), .squelch_o(squelch_o), .valid_o(valid_o), .ready_i(ready_i), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic [31:0] step;
    int          low_idx;
    logic [11:0] low_mag;
    logic [15:0] freq;
    logic        sq;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic [11:0] m);
    valid_in = 1;
    phase_in = p;
    mag_in = m;
    @(negedge clk);
    valid_in = 0;
  endtask

  task automatic blk(input logic [31:0] step);
    repeat (4) begin
      ph += step;
      drive(ph, 12'd1000);
    end
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic mid_test(input bit use_rst);
    do_clear();
    ready_i = 0;
    ph = 0;
    drive(ph, 12'd1000);
    blk(32'h0100_0000);
    @(negedge clk);
    chk("mid_pending_valid", valid_o, 1);
    repeat (2) begin
      ph += 32'h0100_0000;
      drive(ph, 12'd1000);
    end
    if (use_rst) begin
      RST_n = 0;
      @(negedge clk);
      RST_n = 1;
    end else begin
      clear = 1;
      ph += 32'h0100_0000;
      drive(ph, 12'd1000);
      clear = 0;
    end
    chk("mid_valid0", valid_o, 0);
    chk("mid_freq0", freq_o, 0);
    chk("mid_mag0", mag_o, 0);
    chk("mid_sq0", squelch_o, 0);
    ready_i = 1;
    repeat (4) begin
      ph += 32'h0300_0000;
      drive(ph, 12'd1000);
    end
    repeat (2) @(negedge clk);
    chk("mid_no_early_out", valid_o, 0);
    ph += 32'h0300_0000;
    drive(ph, 12'd1000);
    @(negedge clk);
    chk("mid_fresh_valid", valid_o, 1);
    chk("mid_fresh_freq", freq_o, 16'h0300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h0000_0000, 32'h0100_0000, -1, 12'd0,  16'h0100, 1'b0};
    vecs[1]  = '{32'h7F00_0000, 32'h0200_0000, -1, 12'd0,  16'h0200, 1'b0};
    vecs[2]  = '{32'h0000_0000, 32'hFF80_0000, -1, 12'd0,  16'hFF80, 1'b0};
    vecs[3]  = '{32'h1234_5678, 32'h0001_0000, -1, 12'd0,  16'h0001, 1'b0};
    vecs[4]  = '{32'h0000_0000, 32'h0000_FFFF, -1, 12'd0,  16'h0000, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'hFFFF_0001, -1, 12'd0,  16'hFFFF, 1'b0};
    vecs[6]  = '{32'h4000_0000, 32'h8000_0000, -1, 12'd0,  16'h8000, 1'b0};
    vecs[7]  = '{32'h0000_0000, 32'h0100_0000,  2, 12'd10, 16'h0000, 1'b1};
    vecs[8]  = '{32'h0000_0000, 32'h0100_0000,  0, 12'd10, 16'h0000, 1'b1};
    vecs[9]  = '{32'h0000_0000, 32'h0100_0000,  4, 12'd10, 16'h0000, 1'b1};
    vecs[10] = '{32'h0000_0000, 32'h0100_0000,  2, 12'd64, 16'h0100, 1'b0};
    vecs[11] = '{32'h0000_0000, 32'h0100_0000,  3, 12'd63, 16'h0000, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_freq", freq_o, 0);
    chk("rst_mag", mag_o, 0);
    chk("rst_sq", squelch_o, 0);
    chk("rst_overrun", overrun_o, 0);
    RST_n = 1;
    @(negedge clk);

    foreach (vecs[v]) begin
      ready_i = 1;
      do_clear();
      ph = vecs[v].start;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) ph += vecs[v].step;
        drive(ph, i == vecs[v].low_idx ? vecs[v].low_mag : 12'd1000);
      end
      chk($sformatf("vec%0d_latency", v), valid_o, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", v), valid_o, 1);
      chk($sformatf("vec%0d_freq", v), freq_o, vecs[v].freq);
      chk($sformatf("vec%0d_sq", v), squelch_o, vecs[v].sq);
      chk($sformatf("vec%0d_mag", v), mag_o, vecs[v].low_idx == 4 ? vecs[v].low_mag : 12'd1000);
    end

    do_clear();
    ph = 0;
    drive(ph, 12'd1000);
    for (int i = 1; i < 5; i++) begin
      ph += 32'h0100_0000;
      drive(ph, i == 2 ? 12'd10 : 12'd1000);
    end
    @(negedge clk);
    chk("sql_block_sq", squelch_o, 1);
    chk("sql_block_freq", freq_o, 0);
    blk(32'h0100_0000);
    @(negedge clk);
    chk("sql_next_valid", valid_o, 1);
    chk("sql_next_sq", squelch_o, 0);
    chk("sql_next_freq", freq_o, 16'h0100);

    do_clear();
    ready_i = 0;
    ph = 0;
    drive(ph, 12'd1000);
    for (int k = 1; k <= 4; k++) blk(32'(k) << 24);
    @(negedge clk);
    chk("ovr_full_valid", valid_o, 1);
    chk("ovr_not_yet", overrun_o, 0);
    blk(32'h0500_0000);
    repeat (2) @(negedge clk);
    chk("ovr_set", overrun_o, 1);
    chk("ovr_head_kept", freq_o, 16'h0100);
    ready_i = 1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovr_drain%0d", k), freq_o, 32'(k) << 8);
      @(negedge clk);
    end
    chk("ovr_drained", valid_o, 0);
    chk("ovr_sticky", overrun_o, 1);
    do_clear();
    chk("ovr_cleared", overrun_o, 0);

    ready_i = 0;
    ph = 0;
    drive(ph, 12'd1000);
    for (int k = 1; k <= 4; k++) blk(32'(k) << 24);
    repeat (3) begin
      ph += 32'h0500_0000;
      drive(ph, 12'd1000);
    end
    ready_i = 1;
    ph += 32'h0500_0000;
    drive(ph, 12'd1000);
    ready_i = 0;
    repeat (2) @(negedge clk);
    chk("fullpop_no_overrun", overrun_o, 0);
    ready_i = 1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("fullpop_drain%0d", k), freq_o, 32'(k) << 8);
      @(negedge clk);
    end
    chk("fullpop_empty", valid_o, 0);

    mid_test(0);
    mid_test(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cordic_freq_demod.md
# cordic_freq_demod

Downstream stage of the vectoring-mode CORDIC. It consumes the CORDIC's per-sample phase and modulus stream and differentiates the phase, giving instantaneous frequency for FM/FSK demodulation. It averages DECIM differences per output (accumulate-and-dump), zeroes output blocks whose signal level falls below a squelch threshold, and buffers results in a small FIFO behind a ready/valid handshake. The upstream CORDIC pipeline cannot be stalled, so overflow is detected and flagged, never back-pressured.

## Interface
- PH_BITS, 32: width of the phase input; full scale 2^PH_BITS = 2π.
- XY_BITS, 12: width of the modulus input.
- OUT_BITS, 16: width of the frequency output; must be ≤ PH_BITS.
- DECIM, 8: differences averaged per output; power of two, 1..256. LOG2_DECIM is a derived localparam.
- FIFO_DEPTH, 4: output buffer entries; power of two, ≥2.
- SQL_LEVEL, 64: squelch threshold on the modulus (unsigned compare).
- clk  in  1  clock; all logic on rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of all state, including the overrun flag.
- valid_in  in  1  sample strobe (the CORDIC's valid_out).
- phase_in  in  PH_BITS  phase sample, two's-complement angle.
- mag_in  in  XY_BITS  modulus sample, treated as unsigned.
- freq_o  out  OUT_BITS  signed mean phase step; head of FIFO.
- mag_o  out  XY_BITS  modulus of the last sample in the block.
- squelch_o  out  1  block contained a sample below SQL_LEVEL; freq_o is forced to 0.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  downstream accept.
- overrun_o  out  1  sticky; a result was dropped on a full FIFO.

## Operation
- FSM states:
  - S_EMPTY: no previous phase held. The first valid_in stores phase_in into prev_ph, emits no difference, and moves to S_RUN.
  - S_RUN: each valid_in computes diff = phase_in − prev_ph, modulo 2^PH_BITS, read as signed. A wrap across ±π therefore gives the short-way step. prev_ph is then updated.
- Accumulator:
  - Width PH_BITS+LOG2_DECIM; diff is sign-extended before adding. cnt runs 0..DECIM−1.
  - On a valid diff with cnt==DECIM−1 (dump): sum = acc + diff; mean = sum >>> LOG2_DECIM (arithmetic, truncating); result = mean[PH_BITS−1 -: OUT_BITS].
  - After a dump, acc and cnt are zeroed.
- Squelch: low_seen is set by any sample in the block, the S_EMPTY priming sample included, with mag_in < SQL_LEVEL. At dump, if low_seen or the current sample is low, then freq = 0 and squelch = 1. low_seen clears at dump.
- FIFO: each dump pushes {freq, mag_in, squelch}.
  - valid_o = not empty; a pop occurs when valid_o && ready_i.
  - Push when full with a pop in the same cycle: accepted.
  - Push when full with no pop: the result is dropped, FIFO contents are unchanged, and overrun_o is set.
- clear:
  - Returns the FSM to S_EMPTY, zeroes acc, cnt and low_seen, empties the FIFO and clears overrun_o.
  - clear with valid_in in the same cycle: clear wins and the sample is discarded.
  - clear with a pop in the same cycle: flush wins.
- When valid_in is low, all datapath state holds.

## Timing
- Reset values (RST_n low, asynchronous): freq_o = 0, mag_o = 0, squelch_o = 0, valid_o = 0, overrun_o = 0, FSM = S_EMPTY, acc = 0, cnt = 0, prev_ph = 0.
- Latency: a dump sample with valid_in in cycle c produces valid_o in cycle c+2 if the FIFO was empty. The dump result is registered at the end of c and written to the FIFO at the end of c+1.
- Sustained input rate: one sample per clock with no loss, provided the consumer pops at least once per DECIM samples on average.
- Reset deasserted mid-stream: the first sample after reset only primes prev_ph. The first output needs DECIM+1 valid samples.
- freq_o, mag_o and squelch_o are stable while valid_o is high and ready_i is low.

## Structure
- Package cordic_pkg holds:
  - the FIFO entry typedef {freq, mag, squelch};
  - the FSM state enum;
  - the helper computing LOG2_DECIM.
- One sub-module, cordic_sync_fifo: parameterised width/depth, registered outputs, a full/empty pair and a simultaneous push/pop-when-full rule. The top level owns the FSM, difference, accumulator and squelch logic.

## Test plan
- Constant step: DECIM=4, OUT_BITS=16. Phase advancing by 0x0100_0000 per sample, mag 1000, ready_i=1. Outputs freq_o = 0x0100 after 5 samples, then one every 4 samples; squelch_o = 0.
- Wrap-around: phases 0x7F00_0000, 0x8100_0000 repeating +0x0200_0000 steps. Requires freq_o = 0x0200, not negative. A −0x0080_0000 step yields 0xFF80.
- Squelch: one sample with mag 10 inside a block gives freq_o = 0 and squelch_o = 1 for that block only; the next block is normal.
- Overrun: ready_i = 0, FIFO_DEPTH=4. After 4 outputs valid_o stays 1 and the 5th dump sets overrun_o. Draining returns the first 4 results in order, and overrun_o stays 1 until clear.
- Full with simultaneous pop: the FIFO is full, ready_i pulses in the dump cycle, the new result is accepted and overrun_o stays 0.
- Reset/clear mid-block: clear or RST_n low after 2 of 4 samples. All outputs return to 0, and the next output needs 5 fresh samples, with no carry-over from the partial block.
